mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage placed directly downstream of the execute stage and upstream of writeback. It latches the execute-stage bus, captures the synchronous data-RAM read return, and aligns and extends load data. It selects the final result (load / multiply / execute result) and forwards it to writeback. It also drives the forwarding bus and the store-suppression signal back to execute.

## Interface
Parameters
- none; all widths fixed as below.

Ports
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- EXreg_valid  in  1  execute stage holds a valid instruction.
- EX_ready_go  in  1  execute stage result is complete.
- EXreg_bus  in  239  MSB→LSB: ebus[15:0], mul, mul_result[31:0], ex_result[31:0], rkd_value[31:0], ld_ctrl[4:0], ertn_flush, csr_ctrl[79:0], res_from_csr, rf_we, res_from_mem, rf_waddr[4:0], pc[31:0].
- WB_allow_in  in  1  writeback can accept.
- flush  in  1  exception/ertn commit from writeback; kills the stage content.
- data_sram_rdata  in  32  read data, valid the cycle after the execute-stage request.
- MEM_allow_in  out  1  stage can accept from execute.
- MEM_ready_go  out  1  constant 1.
- MEMreg_valid  out  1  valid toward writeback.
- MEMreg_bus  out  200  MSB→LSB: ebus[15:0], vaddr[31:0], ertn_flush, csr_ctrl[79:0], res_from_csr, rf_we, rf_waddr[4:0], pc[31:0], final_result[31:0].
- MEM_bypass_bus  out  39  {res_from_csr, rf_waddr[4:0], rf_we & valid, final_result[31:0]}.
- st_disable  out  1  suppress stores in execute.

## Operation
- ld_ctrl bits: [4] ld_w, [3] ld_bu, [2] ld_b, [1] ld_hu, [0] ld_h.
- Stage register loads on (EX_ready_go & MEM_allow_in). valid_next = EXreg_valid. The whole 239-bit bus is latched.
- MEM_allow_in = ~valid | (MEM_ready_go & WB_allow_in).
- flush=1: valid clears at the next edge. flush overrides a simultaneous load, so no instruction is accepted that cycle.
- Read-data capture:
  - first_cycle flag is set on every load into the stage and cleared on the following edge.
  - When first_cycle=1, data_sram_rdata is written into rdata_buf.
  - Effective read data = first_cycle ? data_sram_rdata : rdata_buf.
  - This keeps correct data across writeback stalls, even when execute issues a new read.
- Alignment uses a = ex_result[1:0]:
  - ld_b / ld_bu select byte a. ld_b sign-extends, ld_bu zero-extends.
  - ld_h / ld_hu select halfword a[1]. ld_h sign-extends, ld_hu zero-extends.
  - ld_w takes the word.
- final_result = mul ? mul_result : res_from_mem ? load_data : ex_result.
- vaddr = ex_result. It is carried for BADV.
- st_disable = valid & ((|ebus) | ertn_flush).
- MEMreg_valid = valid & ~flush.

## Timing
- Reset (asynchronous, reset=0): valid=0, first_cycle=0, rdata_buf=0, stage register=0. Consequently MEMreg_valid=0, MEM_allow_in=1, st_disable=0, and MEM_bypass_bus write-enable=0.
- Latency: one cycle. An instruction accepted at edge N is visible on MEMreg_bus and MEM_bypass_bus during cycle N+1.
- The stage never self-stalls. Its occupancy lasts until WB_allow_in=1.
- Back-to-back loads with no stall give a throughput of one per cycle. In that case first_cycle stays 1 every cycle.
- Stall of k cycles: final_result stays stable for all k+1 cycles. rdata_buf is written only on the first of them.
- flush and a stall in the same cycle: valid clears and the register is not reloaded.
- Reset during a stall: everything clears immediately, with no clock needed.

## Test plan
- ld_b at ex_result=0x1003, rdata=0x80FF_1234 → final_result=0xFFFF_FF80. ld_bu at the same address → 0x0000_0080.
- ld_h at address 0x1002, rdata=0x9ABC_0000 → 0xFFFF_9ABC. ld_hu → 0x0000_9ABC. ld_w → 0x9ABC_0000.
- ld_w accepted, then WB_allow_in=0 for 3 cycles while data_sram_rdata changes to 0xDEAD_BEEF. The original word 0x1111_2222 is held on final_result every cycle, and MEM_allow_in=0 throughout.
- mul=1, mul_result=0x0000_0042, ex_result=0x5 → final_result=0x42. The bypass carries rf_waddr and rf_we=1.
- Valid instruction with ebus=0x0040 → st_disable=1 the same cycle. With ertn_flush=1 → st_disable=1. With flush=1 → MEMreg_valid=0 the same cycle, valid=0 after the edge, and a concurrent execute-stage offer is not accepted.
- reset pulled low mid-stall → MEMreg_valid=0 and MEM_allow_in=1 before the next clock edge.

Source files
------------

// File: rtl/mem_stage_if.sv
// Execute->memory->writeback handshake and bus bundle for the memory-access stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface mem_stage_if;
  logic         EXreg_valid;
  logic         EX_ready_go;
  logic [238:0] EXreg_bus;
  logic         WB_allow_in;
  logic         flush;
  logic [31:0]  data_sram_rdata;
  logic         MEM_allow_in;
  logic         MEM_ready_go;
  logic         MEMreg_valid;
  logic [199:0] MEMreg_bus;
  logic [38:0]  MEM_bypass_bus;
  logic         st_disable;

  modport master (
    output EXreg_valid, EX_ready_go, EXreg_bus, WB_allow_in, flush, data_sram_rdata,
    input  MEM_allow_in, MEM_ready_go, MEMreg_valid, MEMreg_bus, MEM_bypass_bus, st_disable
  );

  modport slave (
    input  EXreg_valid, EX_ready_go, EXreg_bus, WB_allow_in, flush, data_sram_rdata,
    output MEM_allow_in, MEM_ready_go, MEMreg_valid, MEMreg_bus, MEM_bypass_bus, st_disable
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute bus, holds the synchronous
// RAM read return across stalls, aligns/extends load data and picks the result.
module mem_stage (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);
  logic         valid_reg;
  logic         first_cycle_reg;
  logic [31:0]  rdata_buf_reg;
  logic [238:0] ex_bus_reg;
  logic         load_en;

  assign bus.MEM_ready_go = 1'b1;
  assign bus.MEM_allow_in = ~valid_reg | (bus.MEM_ready_go & bus.WB_allow_in);
  // flush wins over a simultaneous offer from execute
  assign load_en = bus.EX_ready_go & bus.MEM_allow_in & ~bus.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg       <= 1'b0;
      first_cycle_reg <= 1'b0;
      rdata_buf_reg   <= 32'h0;
      ex_bus_reg      <= '0;
    end else begin
      if (bus.flush) begin
        valid_reg <= 1'b0;
      end else if (bus.MEM_allow_in) begin
        valid_reg <= bus.EXreg_valid & bus.EX_ready_go;
      end
      if (load_en) begin
        ex_bus_reg <= bus.EXreg_bus;
      end
      first_cycle_reg <= load_en;
      if (first_cycle_reg) begin
        rdata_buf_reg <= bus.data_sram_rdata;
      end
    end
  end

  logic [15:0] ebus;
  logic        mul;
  logic [31:0] mul_result;
  logic [31:0] ex_result;
  logic [4:0]  ld_ctrl;
  logic        ertn_flush;
  logic [79:0] csr_ctrl;
  logic        res_from_csr;
  logic        rf_we;
  logic        res_from_mem;
  logic [4:0]  rf_waddr;
  logic [31:0] pc;

  assign ebus         = ex_bus_reg[238:223];
  assign mul          = ex_bus_reg[222];
  assign mul_result   = ex_bus_reg[221:190];
  assign ex_result    = ex_bus_reg[189:158];
  assign ld_ctrl      = ex_bus_reg[125:121];
  assign ertn_flush   = ex_bus_reg[120];
  assign csr_ctrl     = ex_bus_reg[119:40];
  assign res_from_csr = ex_bus_reg[39];
  assign rf_we        = ex_bus_reg[38];
  assign res_from_mem = ex_bus_reg[37];
  assign rf_waddr     = ex_bus_reg[36:32];
  assign pc           = ex_bus_reg[31:0];

  // RAM output is only valid in the cycle after the request; later cycles use the buffer
  logic [31:0] rdata_eff;
  assign rdata_eff = first_cycle_reg ? bus.data_sram_rdata : rdata_buf_reg;

  logic [7:0] lane [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata_eff[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign lane_byte = lane[ex_result[1:0]];
  assign lane_half = ex_result[1] ? rdata_eff[31:16] : rdata_eff[15:0];

  always_comb begin
    load_data = rdata_eff;
    if (ld_ctrl[2]) begin
      load_data = {{24{lane_byte[7]}}, lane_byte};
    end else if (ld_ctrl[3]) begin
      load_data = {24'h0, lane_byte};
    end else if (ld_ctrl[0]) begin
      load_data = {{16{lane_half[15]}}, lane_half};
    end else if (ld_ctrl[1]) begin
      load_data = {16'h0, lane_half};
    end
  end

  assign final_result = mul ? mul_result : (res_from_mem ? load_data : ex_result);

  assign bus.MEMreg_valid   = valid_reg & ~bus.flush;
  assign bus.st_disable     = valid_reg & ((|ebus) | ertn_flush);
  assign bus.MEMreg_bus     = {ebus, ex_result, ertn_flush, csr_ctrl, res_from_csr,
                               rf_we, rf_waddr, pc, final_result};
  assign bus.MEM_bypass_bus = {res_from_csr, rf_waddr, rf_we & valid_reg, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table-driven back-to-back loads through a
// scoreboard, plus hand sequences for stall, store suppression, flush and reset.
module tb_mem_stage;
  logic clk;
  logic reset;
  mem_stage_if mif ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  ld;
    logic        mem;
    logic        mul;
    logic [31:0] ex;
    logic [31:0] mr;
    logic [31:0] rd;
    logic [31:0] exp_res;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] pc;
    logic [4:0]  waddr;
  } exp_t;

  vec_t vecs [10];
  exp_t sb_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] ebus, input logic mul, input logic [31:0] mr,
                       input logic [31:0] ex, input logic [4:0] ld, input logic ertn,
                       input logic mem, input logic [4:0] waddr, input logic [31:0] pc,
                       input logic [31:0] exp_res, input logic push);
    mif.EXreg_bus   = {ebus, mul, mr, ex, 32'h0, ld, ertn, 80'h0, 1'b0, 1'b1, mem, waddr, pc};
    mif.EXreg_valid = 1'b1;
    mif.EX_ready_go = 1'b1;
    if (push) sb_q.push_back('{res: exp_res, pc: pc, waddr: waddr});
  endtask

  task automatic idle();
    mif.EXreg_valid = 1'b0;
  endtask

  // Scoreboard monitor: one pop per instruction handed to writeback
  always @(negedge clk) begin
    if (reset && mif.MEMreg_valid && mif.WB_allow_in) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output got=%h expected=none", mif.MEMreg_bus[31:0]);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn pc=%h result=%h expected=%h", mif.MEMreg_bus[63:32],
                 mif.MEMreg_bus[31:0], e.res);
        check("final_result", mif.MEMreg_bus[31:0], e.res);
        check("pc", mif.MEMreg_bus[63:32], e.pc);
        check("bypass_ctrl", {25'h0, mif.MEM_bypass_bus[38:32]}, {25'h0, 1'b0, e.waddr, 1'b1});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{ld: 5'b00100, mem: 1'b1, mul: 1'b0, ex: 32'h0000_1003, mr: 32'h0, rd: 32'h80FF_1234, exp_res: 32'hFFFF_FF80};
    vecs[1] = '{ld: 5'b01000, mem: 1'b1, mul: 1'b0, ex: 32'h0000_1003, mr: 32'h0, rd: 32'h80FF_1234, exp_res: 32'h0000_0080};
    vecs[2] = '{ld: 5'b00001, mem: 1'b1, mul: 1'b0, ex: 32'h0000_1002, mr: 32'h0, rd: 32'h9ABC_0000, exp_res: 32'hFFFF_9ABC};
    vecs[3] = '{ld: 5'b00010, mem: 1'b1, mul: 1'b0, ex: 32'h0000_1002, mr: 32'h0, rd: 32'h9ABC_0000, exp_res: 32'h0000_9ABC};
    vecs[4] = '{ld: 5'b10000, mem: 1'b1, mul: 1'b0, ex: 32'h0000_1002, mr: 32'h0, rd: 32'h9ABC_0000, exp_res: 32'h9ABC_0000};
    vecs[5] = '{ld: 5'b00000, mem: 1'b0, mul: 1'b1, ex: 32'h0000_0005, mr: 32'h0000_0042, rd: 32'hFFFF_FFFF, exp_res: 32'h0000_0042};
    vecs[6] = '{ld: 5'b00000, mem: 1'b0, mul: 1'b0, ex: 32'h1234_5678, mr: 32'hAAAA_AAAA, rd: 32'h5555_5555, exp_res: 32'h1234_5678};
    vecs[7] = '{ld: 5'b00100, mem: 1'b1, mul: 1'b0, ex: 32'h0000_1000, mr: 32'h0, rd: 32'h0000_007F, exp_res: 32'h0000_007F};
    vecs[8] = '{ld: 5'b00001, mem: 1'b1, mul: 1'b0, ex: 32'h0000_1000, mr: 32'h0, rd: 32'h0000_8001, exp_res: 32'hFFFF_8001};
    vecs[9] = '{ld: 5'b01000, mem: 1'b1, mul: 1'b0, ex: 32'h0000_1001, mr: 32'h0, rd: 32'h0000_AB00, exp_res: 32'h0000_00AB};

    reset               = 1'b0;
    mif.EXreg_valid     = 1'b0;
    mif.EX_ready_go     = 1'b0;
    mif.EXreg_bus       = '0;
    mif.WB_allow_in     = 1'b1;
    mif.flush           = 1'b0;
    mif.data_sram_rdata = 32'h0;
    repeat (2) tick();

    check("rst_memreg_valid", {31'h0, mif.MEMreg_valid}, 32'h0);
    check("rst_allow_in", {31'h0, mif.MEM_allow_in}, 32'h1);
    check("rst_st_disable", {31'h0, mif.st_disable}, 32'h0);
    check("rst_bypass_we", {31'h0, mif.MEM_bypass_bus[32]}, 32'h0);
    reset = 1'b1;
    tick();

    // Back-to-back table: read data for vector i-1 arrives while vector i is offered
    for (int i = 0; i < 10; i++) begin
      if (i > 0) mif.data_sram_rdata = vecs[i-1].rd;
      offer(16'h0, vecs[i].mul, vecs[i].mr, vecs[i].ex, vecs[i].ld, 1'b0, vecs[i].mem,
            5'(i + 1), 32'h1C00_0000 + 32'(i * 4), vecs[i].exp_res, 1'b1);
      tick();
    end
    mif.data_sram_rdata = vecs[9].rd;
    idle();
    tick();

    // Writeback stall of 3 cycles while the RAM output changes underneath
    offer(16'h0, 1'b0, 32'h0, 32'h0000_2000, 5'b10000, 1'b0, 1'b1, 5'd20, 32'h1C00_1000,
          32'h1111_2222, 1'b1);
    tick();
    idle();
    mif.WB_allow_in     = 1'b0;
    mif.data_sram_rdata = 32'h1111_2222;
    #1;
    check("stall0_result", mif.MEMreg_bus[31:0], 32'h1111_2222);
    check("stall0_allow_in", {31'h0, mif.MEM_allow_in}, 32'h0);
    check("stall0_vaddr", mif.MEMreg_bus[183:152], 32'h0000_2000);
    for (int k = 1; k < 3; k++) begin
      tick();
      mif.data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      check("stall_result", mif.MEMreg_bus[31:0], 32'h1111_2222);
      check("stall_allow_in", {31'h0, mif.MEM_allow_in}, 32'h0);
    end
    tick();
    mif.WB_allow_in = 1'b1;
    #1;
    check("stall_release_result", mif.MEMreg_bus[31:0], 32'h1111_2222);
    tick();

    // Store suppression from exception bits and ertn
    offer(16'h0040, 1'b0, 32'h0, 32'h0000_0077, 5'b0, 1'b0, 1'b0, 5'd21, 32'h1C00_1100,
          32'h0000_0077, 1'b1);
    tick();
    offer(16'h0000, 1'b0, 32'h0, 32'h0000_0088, 5'b0, 1'b1, 1'b0, 5'd22, 32'h1C00_1104,
          32'h0000_0088, 1'b1);
    #1;
    check("st_disable_ebus", {31'h0, mif.st_disable}, 32'h1);
    tick();
    offer(16'h0000, 1'b0, 32'h0, 32'h0000_0099, 5'b0, 1'b0, 1'b0, 5'd23, 32'h1C00_1108,
          32'h0000_0099, 1'b1);
    #1;
    check("st_disable_ertn", {31'h0, mif.st_disable}, 32'h1);
    tick();
    idle();
    #1;
    check("st_disable_clear", {31'h0, mif.st_disable}, 32'h0);
    tick();

    // Flush kills the held instruction and blocks a concurrent offer
    offer(16'h0, 1'b0, 32'h0, 32'h0000_00AA, 5'b0, 1'b0, 1'b0, 5'd24, 32'h1C00_2000,
          32'h0, 1'b0);
    tick();
    #1;
    check("pre_flush_valid", {31'h0, mif.MEMreg_valid}, 32'h1);
    mif.flush = 1'b1;
    offer(16'h0, 1'b0, 32'h0, 32'h0000_00BB, 5'b0, 1'b0, 1'b0, 5'd25, 32'h1C00_2004,
          32'h0, 1'b0);
    #1;
    check("flush_same_cycle", {31'h0, mif.MEMreg_valid}, 32'h0);
    tick();
    mif.flush = 1'b0;
    idle();
    #1;
    check("flush_no_accept", {31'h0, mif.MEMreg_valid}, 32'h0);
    check("flush_bypass_we", {31'h0, mif.MEM_bypass_bus[32]}, 32'h0);
    tick();

    // Asynchronous reset in the middle of a stall
    offer(16'h0, 1'b0, 32'h0, 32'h0000_00CC, 5'b0, 1'b0, 1'b0, 5'd26, 32'h1C00_3000,
          32'h0, 1'b0);
    tick();
    idle();
    mif.WB_allow_in = 1'b0;
    #1;
    check("prerst_valid", {31'h0, mif.MEMreg_valid}, 32'h1);
    check("prerst_allow_in", {31'h0, mif.MEM_allow_in}, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_valid", {31'h0, mif.MEMreg_valid}, 32'h0);
    check("midrst_allow_in", {31'h0, mif.MEM_allow_in}, 32'h1);
    tick();
    reset = 1'b1;
    mif.WB_allow_in = 1'b1;
    tick();
    tick();

    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
